// File: rtl/edsac_delay_line_pkg.sv
// edsac_delay_line_pkg
// Shared constants for the EDSAC mercury-delay-line emulator: default clock, carrier and
// delay figures, the derived slot geometry (DEF_DECIM, DEF_DEPTH, DEF_PTR_W) and LED
// counter widths. calc_decim/calc_depth let the top recompute the geometry when its
// parameters are overridden.
package edsac_delay_line_pkg;

    localparam int unsigned CLK_FREQ_DEF = 81_000_000;
    localparam int unsigned MOD_FREQ_DEF = 13_500_000;
    localparam int unsigned DELAY_NS_DEF = 1_094_400;

    // Fixed latency from input pin to output pin outside the storage slots.
    localparam int unsigned PIPE = 4;

    // LED0 toggles every 2^HEART_W cycles; LED1/LED2 hold for 2^STRETCH_W cycles.
    localparam int unsigned HEART_W   = 25;
    localparam int unsigned STRETCH_W = 20;

    function automatic int unsigned calc_decim(input int unsigned clk_freq,
                                               input int unsigned mod_freq);
        return clk_freq / mod_freq;
    endfunction

    // Slots = round((round(delay_ns * clk_freq / 1e9) - PIPE) / decim).
    function automatic int unsigned calc_depth(input int unsigned clk_freq,
                                               input int unsigned delay_ns,
                                               input int unsigned decim);
        longint unsigned cycles;
        cycles = (64'(delay_ns) * 64'(clk_freq) + 64'd500_000_000) / 64'd1_000_000_000;
        return 32'((cycles - 64'(PIPE) + 64'(decim / 2)) / 64'(decim));
    endfunction

    localparam int unsigned DEF_DECIM = calc_decim(CLK_FREQ_DEF, MOD_FREQ_DEF);
    localparam int unsigned DEF_DEPTH = calc_depth(CLK_FREQ_DEF, DELAY_NS_DEF, DEF_DECIM);
    localparam int unsigned DEF_PTR_W = $clog2(DEF_DEPTH);

endpackage

// File: rtl/edsac_delay_line_if.sv
// edsac_delay_line_if
// Board-side pin bundle of the delay line.
//   in_sig  : modulated carrier from the receiver (asynchronous)
//   out_sig : delayed modulated carrier to the transducer
//   LED0..4 : heartbeat, input activity, output activity, line filled, reset active
//   SD      : transceiver shutdown, active-high
// slave is the delay-line side, master the board/bench side.
interface edsac_delay_line_if;

    logic in_sig;
    logic out_sig;
    logic LED0;
    logic LED1;
    logic LED2;
    logic LED3;
    logic LED4;
    logic SD;

    modport master (
        output in_sig,
        input  out_sig, LED0, LED1, LED2, LED3, LED4, SD
    );

    modport slave (
        input  in_sig,
        output out_sig, LED0, LED1, LED2, LED3, LED4, SD
    );

endinterface

// File: rtl/edsac_delay_line_slot_ram.sv
// edsac_delay_line_slot_ram
// Single-port Depth x 1 bit storage for the delay line. Read-first with a registered
// read port so it maps onto block RAM. Contents are never reset.
//   clk_i   : core clock
//   en_i    : access strobe (one per slot)
//   addr_i  : shared read/write address
//   wdata_i : bit written this access
//   rdata_o : bit that was at addr_i before this access, valid after the clock edge
module edsac_delay_line_slot_ram #(
    parameter int unsigned Depth = 16,
    parameter int unsigned AddrW = 4
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic             wdata_i,
    output logic             rdata_o
);

    logic mem [Depth];
    logic rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_q      <= mem[addr_i];
            mem[addr_i]  <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/edsac_delay_line.sv
// edsac_delay_line
// Mercury-delay-line emulator for EDSAC serial numbers. Every rising edge of the 13.5 MHz
// carrier on in_sig is reproduced on out_sig one full line delay later, re-timed to the
// core clock. The carrier is sampled into slots of DECIM core cycles; each slot stores one
// bit in a circular RAM of DEPTH entries and is replayed as a half-slot-wide pulse.
//   clk_in : core clock at CLK_FREQ
//   rst    : synchronous active-high reset
//   bus    : pin bundle (in_sig, out_sig, LED0..LED4, SD), slave side
// Build option: define OPEN_DRAIN_OUT_EN to drive out_sig open-drain (0 or Z) instead of
// push-pull; timing is the same in both builds.
module edsac_delay_line
    import edsac_delay_line_pkg::*;
#(
    parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
    parameter int unsigned MOD_FREQ = MOD_FREQ_DEF,
    parameter int unsigned DELAY_NS = DELAY_NS_DEF
) (
    input logic                clk_in,
    input logic                rst,
    edsac_delay_line_if.slave  bus
);

    localparam int unsigned DECIM  = calc_decim(CLK_FREQ, MOD_FREQ);
    localparam int unsigned HALF   = DECIM / 2;
    localparam int unsigned DEPTH  = calc_depth(CLK_FREQ, DELAY_NS, DECIM);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);
    localparam int unsigned SLOT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    // Input conditioning
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic edge_pulse;

    // Slot timing and storage
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              acc_q, acc_d;
    logic              slot_end;
    logic              wr_bit;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              filled;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_bit;

    // Output and status
    logic                 out_q, out_d;
    logic [HEART_W-1:0]   hb_q, hb_d;
    logic                 led0_q, led0_d;
    logic [STRETCH_W-1:0] in_act_q, in_act_d;
    logic [STRETCH_W-1:0] out_act_q, out_act_d;

    edsac_delay_line_slot_ram #(
        .Depth (DEPTH),
        .AddrW (PTR_W)
    ) u_ram (
        .clk_i   (clk_in),
        .en_i    (slot_end),
        .addr_i  (ptr_q),
        .wdata_i (wr_bit),
        .rdata_o (rd_bit)
    );

    always_comb begin
        sync1_d    = bus.in_sig;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        edge_pulse = sync2_q & ~prev_q;

        slot_end = (slot_q == SLOT_W'(DECIM - 1));
        // An edge arriving in the last cycle of a slot still belongs to that slot.
        wr_bit   = acc_q | edge_pulse;
        slot_d   = slot_end ? '0 : slot_q + 1'b1;
        acc_d    = slot_end ? 1'b0 : wr_bit;

        filled     = (fill_q == FILL_W'(DEPTH));
        ptr_d      = ptr_q;
        fill_d     = fill_q;
        rd_valid_d = rd_valid_q;
        if (slot_end) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
            if (!filled) begin
                fill_d = fill_q + 1'b1;
            end
            // The read issued now returns data written after reset only if DEPTH writes
            // already preceded it; otherwise it is stale RAM content.
            rd_valid_d = filled;
        end

        out_d = rd_valid_q & rd_bit & (slot_q < SLOT_W'(HALF));

        hb_d   = hb_q + 1'b1;
        led0_d = led0_q ^ (&hb_q);

        if (edge_pulse) begin
            in_act_d = '1;
        end else if (in_act_q != '0) begin
            in_act_d = in_act_q - 1'b1;
        end else begin
            in_act_d = in_act_q;
        end

        if (out_d & ~out_q) begin
            out_act_d = '1;
        end else if (out_act_q != '0) begin
            out_act_d = out_act_q - 1'b1;
        end else begin
            out_act_d = out_act_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            slot_q     <= '0;
            acc_q      <= 1'b0;
            ptr_q      <= '0;
            fill_q     <= '0;
            rd_valid_q <= 1'b0;
            out_q      <= 1'b0;
            hb_q       <= '0;
            led0_q     <= 1'b0;
            in_act_q   <= '0;
            out_act_q  <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            slot_q     <= slot_d;
            acc_q      <= acc_d;
            ptr_q      <= ptr_d;
            fill_q     <= fill_d;
            rd_valid_q <= rd_valid_d;
            out_q      <= out_d;
            hb_q       <= hb_d;
            led0_q     <= led0_d;
            in_act_q   <= in_act_d;
            out_act_q  <= out_act_d;
        end
    end

`ifdef OPEN_DRAIN_OUT_EN
    // High level comes from the board pull-up.
    assign bus.out_sig = out_q ? 1'bz : 1'b0;
`else
    assign bus.out_sig = out_q;
`endif

    assign bus.LED0 = led0_q;
    assign bus.LED1 = (in_act_q != '0);
    assign bus.LED2 = (out_act_q != '0);
    assign bus.LED3 = filled;
    assign bus.LED4 = rst;
    assign bus.SD   = 1'b0;

endmodule

// File: tb/tb_edsac_delay_line.sv
`timescale 1ns/1ps
module tb_edsac_delay_line;

    // Shortened line: 20 us at 81 MHz is 1620 cycles; (1620 - 4) / 6 rounded = 269 slots.
    localparam int unsigned DELAY_NS = 20_000;
    localparam int DECIM   = 6;
    localparam int DEPTH   = 269;
    localparam int LAT     = DEPTH * DECIM + 4;
    localparam int BIT_CYC = 162;   // 2 us bit period at 81 MHz
    localparam int PULSES  = 12;

    logic   clk_in  = 1'b0;
    logic   rst     = 1'b1;
    longint cyc     = 0;
    longint rst_cyc = 0;

    int n_checks = 0;
    int n_pass   = 0;

    bit     sb_en = 1'b0;
    longint exp_q[$];

    int     n_rise     = 0;
    int     last_width = 0;
    longint rise_cyc   = 0;
    bit     out_prev   = 1'b0;

    edsac_delay_line_if pins ();

    edsac_delay_line #(
        .CLK_FREQ (81_000_000),
        .MOD_FREQ (13_500_000),
        .DELAY_NS (DELAY_NS)
    ) u_dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (pins)
    );

    always #6.173 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp,
                         input longint tol);
        longint d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_checks++;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, obs, exp, tol);
    endtask

    // Output edges are compared in arrival order against the scoreboard.
    always @(negedge clk_in) begin : mon
        bit hi;
        hi = (pins.out_sig !== 1'b0);
        if (hi && !out_prev) begin
            rise_cyc = cyc;
            n_rise++;
            if (sb_en) begin
                if (exp_q.size() == 0) check("extra_edge", 1, 0, 0);
                else check("edge_delay", cyc, exp_q.pop_front(), 3);
            end
        end
        if (!hi && out_prev) last_width = int'(cyc - rise_cyc);
        out_prev = hi;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass,
                 n_checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // An input rising edge set after edge n lands 0..5 cycles past n+LAT depending on
    // slot phase; the scoreboard expects the centre of that window.
    task automatic drive(input logic v);
        if (v && !pins.in_sig && sb_en) exp_q.push_back(cyc + LAT + 2);
        pins.in_sig = v;
        tick();
    endtask

    task automatic send_bit(input logic b);
        for (int p = 0; p < PULSES; p++) begin
            repeat (3) drive(b);
            repeat (3) drive(1'b0);
        end
        repeat (BIT_CYC - PULSES * 6) drive(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rst_cyc = cyc;
        exp_q.delete();
    endtask

    initial begin
        int base;
        int ones;
        int w;
        logic [34:0] word;

        pins.in_sig = 1'b0;
        repeat (4) tick();

        // Reset state
        check("rst_out", pins.out_sig, 0, 0);
        check("rst_led3", pins.LED3, 0, 0);
        check("rst_led4", pins.LED4, 1, 0);
        check("rst_sd", pins.SD, 0, 0);
        check("rst_led1", pins.LED1, 0, 0);
        check("rst_led2", pins.LED2, 0, 0);
        rst = 1'b0;
        rst_cyc = cyc;
        tick();
        check("led4_low", pins.LED4, 0, 0);

        // Fill every slot with ones, then reset: the stale line must never replay.
        sb_en = 1'b0;
        for (int s = 0; s < DEPTH + 2; s++) begin
            repeat (3) drive(1'b1);
            repeat (3) drive(1'b0);
        end
        do_reset();
        sb_en = 1'b1;
        base = n_rise;
        repeat (100) tick();
        drive(1'b1);
        repeat (2) drive(1'b1);
        repeat (3) drive(1'b0);
        while (cyc - rst_cyc < longint'(DEPTH * DECIM - 1)) tick();
        check("led3_before_fill", pins.LED3, 0, 0);
        check("no_out_before_fill", n_rise - base, 0, 0);
        tick();
        check("led3_at_fill", pins.LED3, 1, 0);
        repeat (200) tick();
        check("fill_edge_count", n_rise - base, 1, 0);
        check("fill_queue", exp_q.size(), 0, 0);

        // 35 one-bits
        base = n_rise;
        for (int b = 0; b < 35; b++) send_bit(1'b1);
        check("led1_active", pins.LED1, 1, 0);
        repeat (LAT + 200) tick();
        check("ones_edge_count", n_rise - base, 35 * PULSES, 0);
        check("ones_queue", exp_q.size(), 0, 0);
        check("led2_active", pins.LED2, 1, 0);

        // 35 zero-bits then a quiet period of 1.5 line delays; then a held-high input
        base = n_rise;
        for (int b = 0; b < 35; b++) send_bit(1'b0);
        repeat (LAT * 3 / 2) tick();
        check("zeros_edge_count", n_rise - base, 0, 0);
        check("zeros_out_low", pins.out_sig, 0, 0);
        base = n_rise;
        repeat (500) drive(1'b1);
        drive(1'b0);
        repeat (LAT + 50) tick();
        check("const1_edge_count", n_rise - base, 1, 0);

        // Random numbers, each followed by a spacer bit
        base = n_rise;
        ones = 0;
        for (int n = 0; n < 4; n++) begin
            word = 35'({$urandom(), $urandom()});
            for (int b = 0; b < 35; b++) begin
                send_bit(word[b]);
                ones += int'(word[b]);
            end
            send_bit(1'b0);
        end
        repeat (LAT + 200) tick();
        check("rand_edge_count", n_rise - base, ones * PULSES, 0);
        check("rand_queue", exp_q.size(), 0, 0);

        // Reset for one cycle while the line is replaying
        for (int b = 0; b < 20; b++) send_bit(1'b1);
        w = 0;
        while (pins.out_sig === 1'b0 && w < 400) begin
            tick();
            w++;
        end
        check("out_high_before_rst", (pins.out_sig !== 1'b0), 1, 0);
        rst = 1'b1;
        tick();
        check("mid_rst_out", pins.out_sig, 0, 0);
        check("mid_rst_ptr", u_dut.ptr_q, 0, 0);
        check("mid_rst_led3", pins.LED3, 0, 0);
        rst = 1'b0;
        rst_cyc = cyc;
        exp_q.delete();
        base = n_rise;
        for (int b = 0; b < 10; b++) send_bit(1'b1);
        repeat (LAT + 200) tick();
        check("post_rst_edge_count", n_rise - base, 10 * PULSES, 0);
        check("post_rst_queue", exp_q.size(), 0, 0);

        // Two rising edges two cycles apart, placed at the start of one slot
        while ((cyc - rst_cyc) % DECIM != 4) tick();
        base = n_rise;
        exp_q.push_back(cyc + LAT + 2);
        pins.in_sig = 1'b1;
        tick();
        pins.in_sig = 1'b0;
        tick();
        pins.in_sig = 1'b1;
        tick();
        pins.in_sig = 1'b0;
        repeat (LAT + 50) tick();
        check("double_edge_count", n_rise - base, 1, 0);
        check("double_edge_width", last_width, 3, 0);

        check("final_queue", exp_q.size(), 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/edsac_delay_line.md
Name: edsac_delay_line

Overview:
- Single-clock mercury-delay-line emulator for EDSAC-style serial numbers.
- Input is 13.5 MHz carrier bursts: about 12 carrier cycles per '1' bit, none for '0'. Bits are spaced about 2 µs apart.
- Every input carrier rising edge is reproduced on the output 1.0944 ms later, re-timed to the core clock.
- Top-level FPGA block driving the transducer pin, status LEDs and transceiver shutdown.

Parameters:
- CLK_FREQ, 81_000_000, core clock frequency in Hz; clk_in is supplied by the board PLL at this rate.
- MOD_FREQ, 13_500_000, carrier frequency in Hz.
- DELAY_NS, 1_094_400, required end-to-end delay in ns.
- DECIM, CLK_FREQ/MOD_FREQ (6), core cycles per storage slot.
- DEPTH, (round(DELAY_NS*CLK_FREQ/1e9) - PIPE)/DECIM, giving 14774 slots; PIPE is the fixed pipeline latency (4).

Ports:
- clk_in, input, 1, core clock (CLK_FREQ).
- rst, input, 1, synchronous active-high reset.
- in_sig, input, 1, asynchronous modulated input.
- out_sig, output, 1, delayed modulated output.
- LED0, output, 1, heartbeat.
- LED1, output, 1, input activity.
- LED2, output, 1, output activity.
- LED3, output, 1, line filled.
- LED4, output, 1, reset active.
- SD, output, 1, transceiver shutdown (active-high).

Behaviour:
- Interface: one clock (clk_in); reset rst is synchronous and active-high.
- Input conditioning: in_sig passes through a 2-FF synchroniser, then a rising-edge detector (one-cycle pulse).
- Slot timing: a slot counter runs 0..DECIM-1.
  - Slot bit = 1 if at least one rising edge occurred during the slot.
  - Multiple edges within one slot collapse to a single 1.
- Storage: circular buffer of DEPTH x 1 bit, one shared pointer.
  - At slot end, read the old bit at the pointer, write the new bit, then advance the pointer.
  - The pointer wraps DEPTH-1 -> 0.
  - Read-before-write at the same address gives exactly DEPTH slots of delay.
- Replay: when the read bit = 1, out_sig is high for the first DECIM/2 cycles (3) of the next slot, then low.
  - Output is therefore a 13.5 MHz, 50 % duty pulse per stored edge.
- Latency:
  - Input rising edge to output rising edge = DEPTH*DECIM + PIPE ± DECIM cycles, i.e. 1.0944 ms ± 74 ns.
  - This must stay within one 12 MHz period (83.3 ns).
- Fill guard: a fill counter gates out_sig low until DEPTH slots have been written since reset, so uninitialised RAM is never replayed. LED3 goes high when filled.
- Reset: pointer, slot counter, fill counter, synchroniser and out_sig all go to 0 on the next clock edge. RAM contents are not cleared. Reset mid-operation discards the line and refills.
- Idle input (constant 0 or constant 1): no output edges.
- LED0 toggles every 2^25 cycles.
- LED1 and LED2 are stretched 2^20 cycles from the last input/output edge.
- LED4 = rst.
- SD is driven 0 constantly (transceiver enabled).

Optional Feature:
- Macro OPEN_DRAIN_OUT_EN.
- Defined: out_sig is driven 0 when low and released to high-Z when high; board pull-up or weak pull supplies the level.
- Undefined: out_sig is actively push-pull driven.
- Timing is identical in both builds.

Decomposition:
- Package delay_line_pkg holds:
  - CLK_FREQ, MOD_FREQ, DELAY_NS defaults;
  - derived DECIM, PIPE, DEPTH, pointer width $clog2(DEPTH);
  - LED stretch widths.
- Sub-module slot_ram: simple single-port 1-bit RAM, read-first, registered read, infers block RAM.
- Synchroniser, slot logic and LED counters stay in the top level.

Test Plan:
- After reset, send 35 '1' bits (12 carrier pulses each, 13.5 MHz, 0.9 µs burst + 1 µs gap).
  - Required: 420 output rising edges.
  - Each within 83 ns of its input edge + 1.0944 ms.
- Send 35 '0' bits.
  - Required: out_sig stays 0 for 1.5 ms after the last input.
- Send 20 random 35-bit numbers, each followed by a spacer bit.
  - Required: every output edge is in FIFO order, delay 1.0944 ms ± 83 ns; no extra edges.
- Input edge within the first 1.09 ms after reset, with stale RAM preloaded to all ones.
  - Required: no output before fill; LED3 rises at DEPTH*DECIM cycles.
- Assert rst for 1 cycle midway through a stream.
  - Required: out_sig = 0 next cycle; pointer = 0; output resumes only for edges sent after reset, delayed 1.0944 ms.
- Two input rising edges 2 cycles apart within one slot.
  - Required: exactly one output pulse 3 cycles wide.
  - Build both with and without OPEN_DRAIN_OUT_EN; the open-drain build shows Z instead of 1.
